mem_store_unit: RTL
===================

Name: mem_store_unit

Overview:
- Write-side counterpart to the memory read-address selection in the multicycle CPU datapath.
- Executes SB/SH/SW stores into the shared byte-addressed, big-endian, 32-bit-word memory.
- SB/SH use a read-modify-write sequence; SW is a direct write.
- While active, asserts mem_own so the read-address mux yields the memory port; the control unit stalls on busy.

Parameters:
- ADDR_W, 32, address width in bits.
- READ_LAT, 1, memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req  in  1  store request, sampled only in IDLE
- size  in  2  00=byte, 01=halfword, 10=word, 11=reserved
- addr  in  ADDR_W  byte address of the store
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when the write has been issued
- err  out  1  one-cycle pulse on a rejected request
- mem_own  out  1  memory port owned by this block
- mem_addr  out  ADDR_W  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid READ_LAT cycles after mem_addr

Behaviour:
- Reset (reset==0 at a clk edge) applies in any state, including mid-operation:
  - state goes to IDLE.
  - busy, done, err, mem_own and mem_wr are 0.
  - mem_addr and mem_wdata are 0.
  - A pending write is dropped. No partial write may occur in the reset cycle.
- IDLE, req=1:
  - Latch size, addr and wdata.
  - size=10 goes to WRITE.
  - size=00/01 goes to READ.
  - size=11 pulses err, issues no memory access, and stays in IDLE.
- req while busy is ignored and not queued. The control unit holds req until done.
- READ:
  - mem_own=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wr=0.
  - Next state is WAIT.
  - A down-counter is loaded with READ_LAT-1.
- WAIT:
  - mem_own=1; mem_addr is held.
  - When the counter reaches 0, mem_rdata is captured into a merge register and the state goes to WRITE.
- WRITE:
  - mem_own=1, mem_wr=1 for exactly one cycle.
  - SW: mem_addr = aligned address, mem_wdata = wdata.
  - SB/SH: mem_wdata = merged word (lane rules below), mem_addr = aligned address.
  - Next state is DONE.
- DONE:
  - done=1 for one cycle; mem_own=0; next state is IDLE.
  - A new req is accepted only on the following cycle.
- Lane merge, big-endian:
  - Byte offset 0 maps to [31:24], offset 1 to [23:16], offset 2 to [15:8], offset 3 to [7:0].
  - Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
  - Unwritten lanes keep the captured mem_rdata bytes.
- Latency from req accepted to done:
  - SW: 2 cycles.
  - SB/SH: READ_LAT+3 cycles.
- Misalignment when MISALIGN_TRAP_EN is undefined:
  - SH ignores addr[0].
  - SW ignores addr[1:0].
  - The write proceeds.
- Address wrap: no special handling. The aligned address is always used, so a word never crosses a word boundary.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - SH with addr[0]=1, or SW with addr[1:0]!=0, pulses err in the accept cycle.
  - No memory access occurs, state stays IDLE, and done is not asserted.
  - err is also driven to the CPU exception logic, which later reads a vector byte.
- Undefined: low address bits are silently ignored as described above; err pulses only for size=11.

Decomposition:
- Package mem_store_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encodings ST_IDLE, ST_READ, ST_WAIT, ST_WRITE, ST_DONE.
  - a lane-offset-to-bit-position constant function.
- Sub-module store_lane_merge: purely combinational.
  - Inputs: old word, wdata, size, addr[1:0].
  - Output: merged word.
  - Unit-testable alone.

Test Plan:
- SW, addr=0x40, wdata=0xDEADBEEF -> mem_wr pulse 1 cycle after accept with mem_addr=0x40, mem_wdata=0xDEADBEEF; done 2 cycles after accept.
- SB, addr=0x41, wdata=0x000000AB, memory word at 0x40=0x11223344 -> read at 0x40, write 0x11AB3344; done at READ_LAT+3.
- SH, addr=0x42, wdata=0x0000CAFE, memory word 0x11223344 -> write 0x1122CAFE; bytes 0x40/0x41 unchanged.
- reset=0 asserted during WAIT of an SB -> next cycle IDLE with busy=0, mem_own=0; no mem_wr pulse ever issued.
- req held high through a whole SB, then size=11 -> first request completes once with one done; size=11 request gives a single err pulse and no memory access.
- MISALIGN_TRAP_EN defined, SW at addr=0x43 -> err pulse, mem_wr stays 0, busy stays 0; undefined: write to 0x40.

Source files
------------

// File: rtl/mem_store_pkg.sv
// Shared encodings for mem_store_unit: store sizes, FSM states and the
// big-endian lane position helper.
package mem_store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Big-endian: byte offset 0 is the most significant lane, lsb = (3 - off) * 8.
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational big-endian lane merge: overlays a right-justified byte,
// halfword or word onto a previously read memory word.
module store_lane_merge
  import mem_store_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] OFF = 2'(gi);
    localparam int         LSB = int'(lane_lsb(OFF));

    logic       w_hit;
    logic [7:0] w_new;

    always_comb begin
      w_hit = 1'b0;
      w_new = i_wdata[LSB +: 8];
      case (i_size)
        SZ_BYTE: begin
          w_hit = (i_offset == OFF);
          w_new = i_wdata[7:0];
        end
        SZ_HALF: begin
          // Even offset of the pair carries the high byte of the halfword.
          w_hit = (i_offset[1] == OFF[1]);
          w_new = OFF[0] ? i_wdata[7:0] : i_wdata[15:8];
        end
        SZ_WORD: w_hit = 1'b1;
        default: w_hit = 1'b0;
      endcase
    end

    assign o_merged[LSB +: 8] = w_hit ? w_new : i_old_word[LSB +: 8];
  end

endmodule

// File: rtl/mem_store_unit.sv
// SB/SH/SW store engine for the shared big-endian word memory; sub-word
// stores use read-modify-write. Optional macro MISALIGN_TRAP_EN traps misaligned SH/SW.
module mem_store_unit
  import mem_store_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_old_word;
  logic [1:0]        r_cnt;

  logic              w_bad;
  logic              w_req_idle;
  logic              w_reject;
  logic              w_accept;
  logic [31:0]       w_merged;

  always_comb begin
    w_bad = (size == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
    if (size == SZ_HALF && addr[0]) w_bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) w_bad = 1'b1;
`endif
  end

  assign w_req_idle = (r_state == ST_IDLE) && req;
  assign w_reject   = w_req_idle && w_bad;
  assign w_accept   = w_req_idle && !w_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_old_word <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (r_state == ST_READ) begin
        r_cnt <= LAT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == ST_WAIT && r_cnt == 2'd0) begin
        r_old_word <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = (size == SZ_WORD) ? ST_WRITE : ST_READ;
      ST_READ:  w_next_state = ST_WAIT;
      ST_WAIT:  if (r_cnt == 2'd0) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  store_lane_merge u_merge (
    .i_old_word (r_old_word),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_offset   (r_addr[1:0]),
    .o_merged   (w_merged)
  );

  // Write enable and error are masked by reset so nothing escapes in a reset cycle.
  always_comb begin
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    err       = w_reject && reset;
    mem_own   = (r_state == ST_READ) || (r_state == ST_WAIT) || (r_state == ST_WRITE);
    mem_wr    = (r_state == ST_WRITE) && reset;
    mem_addr  = mem_own ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = mem_wr ? w_merged : '0;
  end

endmodule
